// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if
//  Bundles the two data-side channels of the layer sequencer:
//   - input element stream  (in_valid / in_ready / in_data)
//   - layer datapath control (fill / req / x_data / x_addr / mac_ack / layer_ack)
//  Handshake: an input element transfers on every clock edge where in_valid and
//  in_ready are both high; the producer holds in_data stable while in_valid is high.
//  mac_ack is a one-cycle pulse from the layer meaning x_data has been consumed;
//  layer_ack is a level from the layer meaning its result is ready.
//  Modports:
//   master - the sequencer side (drives in_ready, fill, req, x_data, x_addr)
//   slave  - the producer/layer side (drives in_valid, in_data, mac_ack, layer_ack)
interface nn_layer_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              fill;
    logic              req;
    logic [DATA_W-1:0] x_data;
    logic [IW-1:0]     x_addr;
    logic              mac_ack;
    logic              layer_ack;

    modport master (
        input  in_valid, in_data, mac_ack, layer_ack,
        output in_ready, fill, req, x_data, x_addr
    );

    modport slave (
        output in_valid, in_data, mac_ack, layer_ack,
        input  in_ready, fill, req, x_data, x_addr
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
//  Sequences one fully-connected layer: pulses fill for FILL_LEN cycles so the
//  layer can load weights/bias, buffers one N_IN-element input vector, streams the
//  elements to the MAC one per mac_ack, then waits for layer_ack and pulses done.
//  Optional feature macro: NN_SEQ_TIMEOUT_EN enables a RUN/WAIT watchdog that sets a
//  sticky err and aborts to IDLE after TMO_CYC cycles without progress.
//  Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset
//   start      one-cycle run request, honoured only in IDLE
//   busy       high in every state except IDLE
//   done       one-cycle pulse when the layer result is valid
//   err        sticky watchdog error (always 0 without NN_SEQ_TIMEOUT_EN)
//   dbg_state  current FSM state encoding
//   bus        input stream + layer control channels (master side)
module nn_layer_sequencer #(
    parameter int DATA_W   = 8,
    parameter int N_IN     = 2,
    parameter int FILL_LEN = 2,
    parameter int TMO_CYC  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state,
    nn_layer_sequencer_if.master bus
);
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int FCW = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state;
    logic [FCW-1:0]    fcnt;
    logic [IW-1:0]     lcnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] x_data_q;
    logic [DATA_W-1:0] data_buf [N_IN];
    logic              tmo_hit;

    wire load_beat = (state == S_LOAD) && bus.in_valid;
    wire last_load = (lcnt == IW'(N_IN - 1));
    wire last_idx  = (idx == IW'(N_IN - 1));

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign dbg_state   = state;
    assign bus.in_ready = (state == S_LOAD);
    assign bus.fill     = (state == S_FILL);
    assign bus.req      = (state == S_RUN);
    assign bus.x_data   = x_data_q;
    assign bus.x_addr   = idx;

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tcnt;
    logic          err_q;

    // The counter measures cycles since entering RUN or since the last mac_ack.
    wire tmo_active = ((state == S_RUN) && !bus.mac_ack) || (state == S_WAIT);
    assign tmo_hit  = tmo_active && (tcnt == TW'(TMO_CYC - 1));
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tmo_active && !tmo_hit) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end else if ((state == S_IDLE) && start) begin
            err_q <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Element buffer needs no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            data_buf[lcnt] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fcnt     <= '0;
            lcnt     <= '0;
            idx      <= '0;
            x_data_q <= '0;
        end else if (tmo_hit) begin
            // Watchdog abort skips DONE, so counters are cleared here instead.
            state    <= S_IDLE;
            fcnt     <= '0;
            lcnt     <= '0;
            idx      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fcnt == FCW'(FILL_LEN - 1)) begin
                        state <= S_LOAD;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (last_load) begin
                            state <= S_RUN;
                            // Element 0 must be on x_data in the first RUN cycle; with a
                            // single-element vector it is the beat being accepted now.
                            x_data_q <= (N_IN == 1) ? bus.in_data : data_buf[0];
                        end else begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.mac_ack) begin
                        if (last_idx) begin
                            state <= S_WAIT;
                        end else begin
                            idx      <= idx + 1'b1;
                            x_data_q <= data_buf[idx + IW'(1)];
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.layer_ack) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    fcnt  <= '0;
                    lcnt  <= '0;
                    idx   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer
//  Directed bench for nn_layer_sequencer with N_IN=2, FILL_LEN=2, TMO_CYC=8.
//  Inputs change 1 ns after the rising edge; outputs are checked at that point too.
module tb_nn_layer_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    int exp_done = 0;

    logic [7:0] vals [2];

    nn_layer_sequencer_if #(.DATA_W(8), .N_IN(2)) bus ();

    nn_layer_sequencer #(
        .DATA_W  (8),
        .N_IN    (2),
        .FILL_LEN(2),
        .TMO_CYC (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dbg_state(dbg_state),
        .bus      (bus)
    );

    // clock
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_state"},  {29'd0, dbg_state}, {29'd0, S_IDLE});
        check_eq({tag, "_busy"},   {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},   {31'd0, done}, 32'd0);
        check_eq({tag, "_err"},    {31'd0, err}, 32'd0);
        check_eq({tag, "_fill"},   {31'd0, bus.fill}, 32'd0);
        check_eq({tag, "_req"},    {31'd0, bus.req}, 32'd0);
        check_eq({tag, "_rdy"},    {31'd0, bus.in_ready}, 32'd0);
        check_eq({tag, "_xdata"},  {24'd0, bus.x_data}, 32'd0);
        check_eq({tag, "_xaddr"},  {31'd0, bus.x_addr}, 32'd0);
    endtask

    // start -> FILL x2 -> LOAD (with 'gap' idle cycles before each beat) -> RUN
    task automatic to_run(input int gap);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("fill_state", {29'd0, dbg_state}, {29'd0, S_FILL});
        check_eq("fill_c1",    {31'd0, bus.fill}, 32'd1);
        check_eq("busy_fill",  {31'd0, busy}, 32'd1);
        step();
        check_eq("fill_c2",    {31'd0, bus.fill}, 32'd1);
        step();
        check_eq("fill_end",   {31'd0, bus.fill}, 32'd0);
        check_eq("load_state", {29'd0, dbg_state}, {29'd0, S_LOAD});
        for (int i = 0; i < 2; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom_range(0, 255));
                step();
                check_eq("gap_load", {29'd0, dbg_state}, {29'd0, S_LOAD});
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            step();
            if (i == 0) check_eq("load_rdy_hold", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(0, 255));
        check_eq("run_state", {29'd0, dbg_state}, {29'd0, S_RUN});
        check_eq("run_rdy",   {31'd0, bus.in_ready}, 32'd0);
        check_eq("run_req",   {31'd0, bus.req}, 32'd1);
    endtask

    // RUN with mac_ack two cycles after each element, WAIT, layer_ack 3 cycles after
    // the last mac_ack, DONE. With inject: start in RUN and DONE, mac_ack in WAIT.
    task automatic finish_run(input bit inject);
        for (int i = 0; i < 2; i++) begin
            check_eq("x_data", {24'd0, bus.x_data}, {24'd0, vals[i]});
            check_eq("x_addr", {31'd0, bus.x_addr}, i);
            check_eq("req_hi", {31'd0, bus.req}, 32'd1);
            start = inject && (i == 0);
            step();
            start = 1'b0;
            check_eq("run_hold", {29'd0, dbg_state}, {29'd0, S_RUN});
            step();
            bus.mac_ack = 1'b1;
            step();
            bus.mac_ack = 1'b0;
        end
        check_eq("wait_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
        check_eq("wait_req",   {31'd0, bus.req}, 32'd0);
        bus.mac_ack = inject;
        step();
        bus.mac_ack = 1'b0;
        check_eq("wait_hold", {29'd0, dbg_state}, {29'd0, S_WAIT});
        step();
        bus.layer_ack = 1'b1;
        step();
        bus.layer_ack = 1'b0;
        exp_done++;
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("done_state", {29'd0, dbg_state}, {29'd0, S_DONE});
        check_eq("done_busy",  {31'd0, busy}, 32'd1);
        start = inject;
        step();
        start = 1'b0;
        check_eq("done_low",   {31'd0, done}, 32'd0);
        check_eq("post_idle",  {29'd0, dbg_state}, {29'd0, S_IDLE});
        check_eq("post_busy",  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vals[0] = 8'h10;
        vals[1] = 8'h20;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mac_ack   = 1'b0;
        bus.layer_ack = 1'b0;

        // clock/reset
        repeat (3) step();
        check_idle_outputs("rst_init");
        rst = 1'b1;
        step();
        check_idle_outputs("rst_rel");

        // 1: reset in the middle of RUN
        to_run(0);
        step();
        #2 rst = 1'b0;
        #1 check_idle_outputs("rst_async");
        step();
        step();
        rst = 1'b1;
        step();
        check_idle_outputs("rst_mid");

        // 2: nominal
        to_run(0);
        finish_run(1'b0);

        // 3: input backpressure
        to_run(3);
        finish_run(1'b0);

        // 4: ignored start / mac_ack
        to_run(0);
        finish_run(1'b1);

        // 6: back-to-back runs
        to_run(0);
        finish_run(1'b0);
        to_run(0);
        finish_run(1'b0);
        check_eq("err_nominal", {31'd0, err}, 32'd0);

`ifdef NN_SEQ_TIMEOUT_EN
        // 5: watchdog in WAIT
        to_run(0);
        for (int i = 0; i < 2; i++) begin
            bus.mac_ack = 1'b1;
            step();
            bus.mac_ack = 1'b0;
        end
        check_eq("tmo_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
        for (int c = 2; c <= 8; c++) begin
            step();
            check_eq("tmo_pre", {31'd0, err}, 32'd0);
            check_eq("tmo_pre_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
        end
        step();
        check_eq("tmo_err",   {31'd0, err}, 32'd1);
        check_eq("tmo_busy",  {31'd0, busy}, 32'd0);
        check_eq("tmo_req",   {31'd0, bus.req}, 32'd0);
        step();
        check_eq("tmo_sticky", {31'd0, err}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("tmo_clear", {31'd0, err}, 32'd0);
        check_eq("tmo_restart", {29'd0, dbg_state}, {29'd0, S_FILL});
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
        step();
`endif

        step();
        check_eq("done_count", n_done, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
